// File: rtl/rca_arbiter_pkg.sv
// Shared definitions for the round-robin adder arbiter: operand width,
// FSM state encoding and the round-robin index step.
package rca_arbiter_pkg;

    localparam int ADD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    function automatic int rr_next(input int idx, input int n);
        if (idx >= n - 1) begin
            return 0;
        end else begin
            return idx + 1;
        end
    endfunction

endpackage

// File: rtl/RCA32.sv
// 32-bit ripple-carry adder built from a chain of full adders.
module RCA32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] S,
    output logic        Cout
);

    logic [32:0] c_s;

    assign c_s[0] = Cin;

    for (genvar i = 0; i < 32; i++) begin : g_fa
        assign S[i]     = A[i] ^ B[i] ^ c_s[i];
        assign c_s[i+1] = (A[i] & B[i]) | (c_s[i] & (A[i] ^ B[i]));
    end

    assign Cout = c_s[32];

endmodule

// File: rtl/rr_pick.sv
// Round-robin winner selection: first valid requester after last_i, wrapping.
module rr_pick
    import rca_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IDW-1:0]  last_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    int   cand_s;
    logic found_s;

    // Walk the indices last+1, last+2, ... and keep the first valid one.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found_s = 1'b0;
        cand_s  = rr_next(int'(last_i), NREQ);
        for (int k = 0; k < NREQ; k++) begin
            if (!found_s && valid_i[cand_s]) begin
                found_s         = 1'b1;
                grant_o[cand_s] = 1'b1;
                idx_o           = IDW'(cand_s);
            end else begin
                found_s = found_s;
            end
            cand_s = rr_next(cand_s, NREQ);
        end
        any_o = found_s;
    end

endmodule

// File: rtl/rca_arbiter.sv
// Shares one RCA32 between NREQ requesters: grant, latch operands, let the
// ripple settle for a cycle, then return sum/carry with the requester ID.
module rca_arbiter
    import rca_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*ADD_W-1:0] req_a,
    input  logic [NREQ*ADD_W-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ADD_W-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic [IDW-1:0]        rsp_id
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   last_q;
    logic [IDW-1:0]   id_q;
    logic [ADD_W-1:0] a_q, b_q;
    logic             cin_q;
    logic [ADD_W-1:0] sum_q;
    logic             cout_q;

    logic [NREQ-1:0]  grant_s;
    logic [IDW-1:0]   pick_idx_s;
    logic             pick_any_s;
    logic             take_s;
    logic [ADD_W-1:0] add_s_s;
    logic             add_cout_s;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .valid_i (req_valid),
        .last_i  (last_q),
        .grant_o (grant_s),
        .idx_o   (pick_idx_s),
        .any_o   (pick_any_s)
    );

    RCA32 u_rca (
        .A    (a_q),
        .B    (b_q),
        .Cin  (cin_q),
        .S    (add_s_s),
        .Cout (add_cout_s)
    );

    // Next state and grant; a grant during reset is suppressed so it cannot be acted on.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        take_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s && !rst) begin
                    req_ready = grant_s;
                    take_s    = 1'b1;
                    state_d   = ST_ADD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADD: begin
                state_d = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RSP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand latching and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= IDW'(NREQ - 1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take_s) begin
                a_q    <= req_a[int'(pick_idx_s)*ADD_W +: ADD_W];
                b_q    <= req_b[int'(pick_idx_s)*ADD_W +: ADD_W];
                cin_q  <= req_cin[pick_idx_s];
                id_q   <= pick_idx_s;
                last_q <= pick_idx_s;
            end
            if (state_q == ST_ADD) begin
                sum_q  <= add_s_s;
                cout_q <= add_cout_s;
            end
        end
    end

    assign rsp_valid = (state_q == ST_RSP);
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_rca_arbiter.sv
// Directed self-checking bench for rca_arbiter with hand-computed results.
module tb_rca_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a;
    logic [NREQ*32-1:0]   req_b;
    logic [NREQ-1:0]      req_cin;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_sum;
    logic                 rsp_cout;
    logic [IDW-1:0]       rsp_id;

    int n_checks = 0;
    int n_fail   = 0;

    rca_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic cin);
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        req_cin[id]        = cin;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
        check_eq({tag, ".rsp_sum"},   64'(rsp_sum),   64'd0);
        check_eq({tag, ".rsp_cout"},  64'(rsp_cout),  64'd0);
        check_eq({tag, ".rsp_id"},    64'(rsp_id),    64'd0);
        check_eq({tag, ".req_ready"}, 64'(req_ready), 64'd0);
    endtask

    // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle again.
    task automatic do_op(input string tag, input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic [31:0] exp_sum, input logic exp_cout);
        set_req(id, a, b, cin);
        req_valid = 4'(1 << id);
        #1;
        check_eq({tag, ".grant"}, 64'(req_ready), 64'(1 << id));
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        check_eq({tag, ".ready_add"}, 64'(req_ready), 64'd0);
        check_eq({tag, ".valid_add"}, 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check_eq({tag, ".valid"}, 64'(rsp_valid), 64'd1);
        check_eq({tag, ".sum"},   64'(rsp_sum),   64'(exp_sum));
        check_eq({tag, ".cout"},  64'(rsp_cout),  64'(exp_cout));
        check_eq({tag, ".id"},    64'(rsp_id),    64'(id));
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        do_op("single", 0, 32'd10, 32'd20, 1'b0, 32'd30, 1'b0);
        do_op("carry", 2, 32'hffffffff, 32'd3, 1'b0, 32'h2, 1'b1);
        do_op("cin", 3, 32'hffff0000, 32'h000205da, 1'b1, 32'h000105db, 1'b1);

        // Back-pressure with requester 0 pending behind requester 1.
        rsp_ready = 1'b0;
        set_req(1, 32'he3244bbe, 32'h0d332ff2, 1'b0);
        req_valid = 4'b0010;
        #1;
        check_eq("bp.grant", 64'(req_ready), 64'h2);
        @(negedge clk);
        set_req(0, 32'd5, 32'd6, 1'b0);
        req_valid = 4'b0001;
        #1;
        check_eq("bp.ready_add", 64'(req_ready), 64'd0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            check_eq("bp.valid", 64'(rsp_valid), 64'd1);
            check_eq("bp.sum",   64'(rsp_sum),   64'hf0577bb0);
            check_eq("bp.cout",  64'(rsp_cout),  64'd0);
            check_eq("bp.id",    64'(rsp_id),    64'd1);
            check_eq("bp.ready", 64'(req_ready), 64'd0);
            if (c < 4) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("bp.next_grant", 64'(req_ready), 64'h1);
        check_eq("bp.idle_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        check_eq("bp.r0_sum", 64'(rsp_sum), 64'd11);
        check_eq("bp.r0_id",  64'(rsp_id),  64'd0);
        @(negedge clk);

        // Reset during ADD drops the transaction and restores priority to requester 0.
        set_req(2, 32'd1, 32'd1, 1'b0);
        req_valid = 4'b0100;
        #1;
        check_eq("rmid.grant", 64'(req_ready), 64'h4);
        @(negedge clk);
        req_valid = 4'b0000;
        rst       = 1'b1;
        @(negedge clk);
        check_reset_outputs("rmid");
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_eq("rmid.no_rsp", 64'(rsp_valid), 64'd0);
        end
        set_req(3, 32'd7, 32'd8, 1'b0);
        set_req(0, 32'd100, 32'd200, 1'b0);
        req_valid = 4'b1001;
        #1;
        check_eq("rmid.first_grant", 64'(req_ready), 64'h1);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        check_eq("rmid.sum", 64'(rsp_sum), 64'd300);
        check_eq("rmid.id",  64'(rsp_id),  64'd0);
        @(negedge clk);

        // Round-robin with all requesters valid from reset.
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(i), 32'(i), 1'b0);
        req_valid = 4'b1111;
        @(negedge clk);
        #1;
        check_eq("rr.ready_in_reset", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int g = 0; g < 5; g++) begin
            int exp_id;
            exp_id = g % NREQ;
            check_eq("rr.grant", 64'(req_ready), 64'(1 << exp_id));
            @(negedge clk);
            @(negedge clk);
            check_eq("rr.sum", 64'(rsp_sum), 64'(2 * exp_id));
            check_eq("rr.id",  64'(rsp_id),  64'(exp_id));
            @(negedge clk);
            #1;
        end
        req_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
